// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared phase encoding and phase-class helpers for the traffic scheduler
//
// Phase codes mirror the two-road light FSM state encoding. The helpers are
// shared by the scheduler, the light FSM and the testbench so that all of
// them classify phases identically.

package traffic_pkg;

    typedef enum logic [2:0] {
        PH_G2  = 3'b000,   // road2 green
        PH_Y2  = 3'b001,   // road2 yellow
        PH_AR1 = 3'b010,   // all-red, heading to road1
        PH_G1  = 3'b011,   // road1 green
        PH_Y1  = 3'b100,   // road1 yellow
        PH_AR2 = 3'b101    // all-red, heading to road2
    } phase_e;

    function automatic logic is_green(input logic [2:0] ph);
        return (ph == PH_G2) || (ph == PH_G1);
    endfunction

    function automatic logic is_allred(input logic [2:0] ph);
        return (ph == PH_AR1) || (ph == PH_AR2);
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// rtl/dwell_timer.sv - saturating dwell counter with synchronous clear
//
// Ports:
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset (count -> 0)
//   clr_i  in  synchronous clear, takes priority over counting
//   cnt_o  out current count, holds at all-ones instead of wrapping

module dwell_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/traffic_phase_scheduler.sv
// rtl/traffic_phase_scheduler.sv - demand-actuated sequencer driving the light FSM advance input
//
// Drives the advance input m of the 6-state two-road light FSM and keeps a
// registered mirror of that FSM's state, advanced with the same transition
// rules, so phase always equals the light state. Enforces min/max green,
// all-red clearance and latched detector demand.
//
// Optional build macro: TRAFFIC_SCHED_PED_EN (pedestrian walk extension of
// the all-red phase). Without it ped_req is ignored and ped_walk is 0.
//
// Ports:
//   clk        in   clock shared with the light FSM
//   rst_n      in   asynchronous active-low reset
//   en         in   1 = scheduling active, 0 = hold green / all-red
//   car_req1   in   road-1 detector
//   car_req2   in   road-2 detector
//   ped_req    in   pedestrian button
//   m          out  advance to light FSM
//   phase      out  mirrored light state
//   dwell_cnt  out  cycles spent in current phase
//   pend1      out  road-1 demand latched
//   pend2      out  road-2 demand latched
//   ped_walk   out  walk indication

module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int MIN_GREEN   = 10,
    parameter int MAX_GREEN   = 60,
    parameter int ALLRED_T    = 3,
    parameter int SKIP_ALLRED = 0,
    parameter int PED_T       = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             car_req1,
    input  logic             car_req2,
    input  logic             ped_req,
    output logic             m,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] dwell_cnt,
    output logic             pend1,
    output logic             pend2,
    output logic             ped_walk
);

    // Thresholds are compared against the count of the current cycle, so a
    // phase of N cycles asserts m when the count reaches N-1.
    localparam logic [CNT_W-1:0] MIN_TH = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_TH = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] AR_TH  = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] PED_TH = CNT_W'(ALLRED_T + PED_T - 1);
    localparam logic             SKIP   = (SKIP_ALLRED != 0);

    phase_e           phase_q;
    phase_e           phase_d;
    logic             pend1_q;
    logic             pend1_d;
    logic             pend2_q;
    logic             pend2_d;
    logic             phase_chg;
    logic             m_int;
    logic [CNT_W-1:0] dwell;
    logic [CNT_W-1:0] ar_th;
    logic             yellow_m;

    dwell_timer #(
        .CNT_W (CNT_W)
    ) u_dwell_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (phase_chg),
        .cnt_o (dwell)
    );

`ifdef TRAFFIC_SCHED_PED_EN
    logic ped_pend_q;
    logic ped_pend_d;
    // Set on entry to an all-red phase when a walk was pending; selects the
    // extended clearance for the whole of that all-red phase.
    logic ped_ext_q;
    logic ped_ext_d;

    assign ar_th    = ped_ext_q ? PED_TH : AR_TH;
    assign yellow_m = SKIP && !ped_pend_q;

    always_comb begin
        ped_ext_d  = ped_ext_q;
        ped_pend_d = ped_pend_q;
        if (phase_chg) begin
            ped_ext_d = is_allred(phase_d) && ped_pend_q;
            if (ped_ext_q && is_allred(phase_q)) begin
                ped_pend_d = 1'b0;
            end
        end
        // A press in the exit cycle belongs to the next crossing.
        if (ped_req) begin
            ped_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ped_pend_q <= 1'b0;
            ped_ext_q  <= 1'b0;
        end else begin
            ped_pend_q <= ped_pend_d;
            ped_ext_q  <= ped_ext_d;
        end
    end

    assign ped_walk = ped_ext_q && is_allred(phase_q) && (dwell >= AR_TH);
`else
    logic unused_ped;

    assign ar_th      = AR_TH;
    assign yellow_m   = SKIP;
    assign ped_walk   = 1'b0;
    assign unused_ped = ped_req | (|PED_TH);
`endif

    // Advance decode. Depends only on registered state plus en, so detector
    // inputs never reach m combinationally.
    always_comb begin
        m_int = 1'b0;
        case (phase_q)
            PH_G2:          m_int = en && (((dwell >= MIN_TH) && pend1_q) || (dwell >= MAX_TH));
            PH_G1:          m_int = en && (((dwell >= MIN_TH) && pend2_q) || (dwell >= MAX_TH));
            PH_Y2, PH_Y1:   m_int = yellow_m;
            PH_AR1, PH_AR2: m_int = en && (dwell >= ar_th);
            default:        m_int = 1'b0;
        endcase
    end

    // Same transition rules as the light FSM, so the mirror tracks it exactly.
    always_comb begin
        phase_d = PH_G2;
        case (phase_q)
            PH_G2:   phase_d = m_int ? PH_Y2 : PH_G2;
            PH_Y2:   phase_d = m_int ? PH_G1 : PH_AR1;
            PH_AR1:  phase_d = m_int ? PH_G1 : PH_AR1;
            PH_G1:   phase_d = m_int ? PH_Y1 : PH_G1;
            PH_Y1:   phase_d = m_int ? PH_G2 : PH_AR2;
            PH_AR2:  phase_d = m_int ? PH_G2 : PH_AR2;
            default: phase_d = PH_G2;
        endcase
    end

    assign phase_chg = (phase_d != phase_q);

    // A car arriving as its own green starts is served by that green, so the
    // clear beats the set.
    always_comb begin
        pend1_d = pend1_q || car_req1;
        pend2_d = pend2_q || car_req2;
        if (phase_chg && (phase_d == PH_G1)) begin
            pend1_d = 1'b0;
        end
        if (phase_chg && (phase_d == PH_G2)) begin
            pend2_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_G2;
            pend1_q <= 1'b0;
            pend2_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            pend1_q <= pend1_d;
            pend2_q <= pend2_d;
        end
    end

    assign m         = m_int;
    assign phase     = phase_q;
    assign dwell_cnt = dwell;
    assign pend1     = pend1_q;
    assign pend2     = pend2_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb/tb_traffic_phase_scheduler.sv - scoreboard bench for traffic_phase_scheduler

module tb_traffic_phase_scheduler;
    import traffic_pkg::*;

    localparam int CNT_W     = 8;
    localparam int MIN_G     = 10;
    localparam int MAX_G     = 60;
    localparam int AR_T      = 3;
    localparam int SKIP      = 0;
    localparam int PED_T     = 20;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             car_req1 = 1'b0;
    logic             car_req2 = 1'b0;
    logic             ped_req = 1'b0;
    logic             m;
    logic [2:0]       phase;
    logic [CNT_W-1:0] dwell_cnt;
    logic             pend1;
    logic             pend2;
    logic             ped_walk;

    traffic_phase_scheduler #(
        .CNT_W       (CNT_W),
        .MIN_GREEN   (MIN_G),
        .MAX_GREEN   (MAX_G),
        .ALLRED_T    (AR_T),
        .SKIP_ALLRED (SKIP),
        .PED_T       (PED_T)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .car_req1  (car_req1),
        .car_req2  (car_req2),
        .ped_req   (ped_req),
        .m         (m),
        .phase     (phase),
        .dwell_cnt (dwell_cnt),
        .pend1     (pend1),
        .pend2     (pend2),
        .ped_walk  (ped_walk)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Light FSM, reset by ~rst_n and advanced by the scheduler's m.
    wire light_rst = ~rst_n;
    int  lst;
    always @(posedge clk or posedge light_rst) begin
        if (light_rst) lst <= 0;
        else begin
            case (lst)
                0: lst <= m ? 1 : 0;
                1: lst <= m ? 3 : 2;
                2: lst <= m ? 3 : 2;
                3: lst <= m ? 4 : 3;
                4: lst <= m ? 0 : 5;
                5: lst <= m ? 0 : 5;
                default: lst <= 0;
            endcase
        end
    end

    // Reference model: phase/dwell/demand state advanced from the rules.
    int nxt [0:5][0:1] = '{'{0, 1}, '{2, 3}, '{2, 3}, '{3, 4}, '{5, 0}, '{5, 0}};
    int mph, mdw;
    bit mp1, mp2, mpp, mpx;

    function automatic bit model_m(input bit e);
        int lim;
        if (is_green(3'(mph))) begin
            bit other = (mph == 0) ? mp1 : mp2;
            return e && ((mdw >= MIN_G - 1 && other) || mdw >= MAX_G - 1);
        end
        if (is_allred(3'(mph))) begin
            lim = AR_T + (mpx ? PED_T : 0);
            return e && (mdw >= lim - 1);
        end
        return (SKIP != 0) && !mpp;
    endfunction

    function automatic bit model_walk();
        return mpx && is_allred(3'(mph)) && (mdw >= AR_T - 1);
    endfunction

    task automatic model_reset();
        mph = 0; mdw = 0; mp1 = 0; mp2 = 0; mpp = 0; mpx = 0;
    endtask

    task automatic model_step(input bit e, input bit r1, input bit r2, input bit pr);
        bit mm, ch, clrp;
        int nx;
        mm = model_m(e);
        nx = nxt[mph][mm];
        ch = (nx != mph);
        mp1 = (mp1 || r1) && !(ch && nx == 3);
        mp2 = (mp2 || r2) && !(ch && nx == 0);
`ifdef TRAFFIC_SCHED_PED_EN
        clrp = ch && mpx && is_allred(3'(mph));
        if (ch) mpx = is_allred(3'(nx)) && mpp;
        mpp = pr || (mpp && !clrp);
`else
        clrp = pr;
        mpp = 0;
        mpx = 0;
`endif
        mdw = ch ? 0 : ((mdw < CNT_MAX) ? mdw + 1 : CNT_MAX);
        mph = nx;
    endtask

    typedef struct {
        int ph;
        int dw;
        bit m;
        bit p1;
        bit p2;
        bit walk;
    } exp_t;
    exp_t sbq[$];

    int obs_phase, obs_dwell;
    bit obs_m, obs_pend1, obs_pend2, obs_walk;

    // Driver: inputs at negedge, expectation pushed, model advanced at posedge.
    task automatic step(input bit e, input bit r1, input bit r2, input bit pr);
        exp_t x;
        @(negedge clk);
        en = e; car_req1 = r1; car_req2 = r2; ped_req = pr;
        #1;
        x.ph = mph; x.dw = mdw; x.m = model_m(e);
        x.p1 = mp1; x.p2 = mp2; x.walk = model_walk();
        sbq.push_back(x);
        obs_phase = phase; obs_dwell = dwell_cnt; obs_m = m;
        obs_pend1 = pend1; obs_pend2 = pend2; obs_walk = ped_walk;
        @(posedge clk);
        model_step(e, r1, r2, pr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        en = 1'b1; car_req1 = 1'b0; car_req2 = 1'b0; ped_req = 1'b0;
        model_reset();
        #1;
        chk("rst_phase", phase, 0);
        chk("rst_dwell", dwell_cnt, 0);
        chk("rst_pend1", pend1, 0);
        chk("rst_pend2", pend2, 0);
        chk("rst_m", m, 0);
        chk("rst_walk", ped_walk, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Monitor: every driven cycle presents outputs; pop and compare.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("phase", phase, e.ph);
            chk("dwell_cnt", dwell_cnt, e.dw);
            chk("m", m, e.m);
            chk("pend1", pend1, e.p1);
            chk("pend2", pend2, e.p2);
            chk("ped_walk", ped_walk, e.walk);
            chk("mirror_vs_light", phase, lst);
        end
    end

    int ph_log [0:199];
    bit p1_log [0:199];
    int cnt [0:7];

    initial begin
        int nhigh;
        bit hit;
        model_reset();

        // No demand: 60 green, 1 yellow, 3 all-red, 60 green, then yellow.
        do_reset();
        for (int i = 0; i < 8; i++) cnt[i] = 0;
        for (int i = 0; i < 125; i++) begin
            step(1, 0, 0, 0);
            ph_log[i] = obs_phase;
            if (obs_phase >= 0 && obs_phase < 8) cnt[obs_phase]++;
        end
        chk("nodem_g2_len", cnt[0], 60);
        chk("nodem_y2_len", cnt[1], 1);
        chk("nodem_ar_len", cnt[2], 3);
        chk("nodem_g1_len", cnt[3], 60);
        chk("nodem_y1_at_124", ph_log[124], 4);

        // Road-1 demand at dwell 2 gaps out road-2 green after 10 cycles.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(1, i == 2, 0, 0);
            ph_log[i] = obs_phase;
            p1_log[i] = obs_pend1;
        end
        chk("dem_m_at_9", ph_log[9], 0);
        chk("dem_y2_at_10", ph_log[10], 1);
        chk("dem_pend1_set", p1_log[3], 1);
        chk("dem_pend1_held", p1_log[13], 1);
        chk("dem_g1_at_14", ph_log[14], 3);
        chk("dem_pend1_clr", p1_log[14], 0);

        // en=0 in road-1 green from dwell 5 to 70 with road-2 demand.
        step(1, 0, 1, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        nhigh = 0;
        for (int i = 5; i <= 70; i++) begin
            step(0, 0, 0, 0);
            if (obs_m) nhigh++;
        end
        chk("en0_m_high_cycles", nhigh, 0);
        step(1, 0, 0, 0);
        chk("en1_dwell", obs_dwell, 71);
        chk("en1_m", obs_m, 1);
        step(1, 0, 0, 0);
        chk("en1_y1", obs_phase, 4);

        // car_req2 on the edge that enters road-2 green: clear wins.
        hit = 0;
        for (int i = 0; i < 10 && !hit; i++) begin
            hit = (mph == 5) && model_m(1);
            step(1, 0, hit, 0);
        end
        chk("entry_hit", hit, 1);
        step(1, 0, 0, 0);
        chk("entry_phase", obs_phase, 0);
        chk("entry_pend2", obs_pend2, 0);

        // Reset mid-sequence from road-1 green, dwell 7.
        do_reset();
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            step(1, i == 0, 0, 0);
            hit = (obs_phase == 3) && (obs_dwell == 7);
        end
        chk("mid_reached", hit, 1);
        do_reset();
        step(1, 0, 0, 0);
        chk("mid_rel_phase", obs_phase, 0);
        chk("mid_rel_m", obs_m, 0);

`ifdef TRAFFIC_SCHED_PED_EN
        // Pedestrian: all-red to road1 lasts 23 cycles, walk for 21 of them.
        do_reset();
        for (int i = 0; i < 8; i++) cnt[i] = 0;
        nhigh = 0;
        for (int i = 0; i < 86; i++) begin
            step(1, 0, 0, i == 3);
            if (obs_phase >= 0 && obs_phase < 8) cnt[obs_phase]++;
            if (obs_walk) nhigh++;
        end
        chk("ped_ar_len", cnt[2], 23);
        chk("ped_walk_len", nhigh, 21);
`endif

        // Randomized traffic with occasional enable drops and resets.
        do_reset();
        for (int i = 0; i < 5000; i++) begin
            bit e, r1, r2, pr;
            if ($urandom_range(0, 1499) == 0) do_reset();
            e  = ($urandom_range(0, 9) != 0);
            r1 = ($urandom_range(0, 49) == 0);
            r2 = ($urandom_range(0, 49) == 0);
            pr = ($urandom_range(0, 199) == 0);
            step(e, r1, r2, pr);
        end

        repeat (3) @(negedge clk);
        #5;
        chk("scoreboard_drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
- Timed, demand-actuated sequencer that drives the advance input `m` of the existing 6-state two-road traffic-light FSM.
- Keeps a registered mirror of the light FSM state. It applies the light FSM's own transition rules to the `m` it drives, so the mirror never diverges.
- Enforces min/max green, all-red clearance, and latched vehicle-detector demand.
- Sits beside the light FSM and shares its clock. Top level drives the light FSM's active-high `rst` as `~rst_n`.

Parameters:
- CNT_W, 8: dwell counter width.
- MIN_GREEN, 10: minimum green cycles before a demand gap-out.
- MAX_GREEN, 60: green cycles after which advance is forced. Requires MIN_GREEN <= MAX_GREEN <= 2^CNT_W-1.
- ALLRED_T, 3: all-red clearance cycles, >= 1.
- SKIP_ALLRED, 0: 1 drives m=1 in yellow phases, bypassing all-red.
- PED_T, 20: extra all-red walk cycles (optional feature only).

Ports:
- clk  in  1  system clock, shared with light FSM.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  1 = scheduling active; 0 = hold current green/all-red.
- car_req1  in  1  road-1 detector pulse or level (synchronous).
- car_req2  in  1  road-2 detector pulse or level (synchronous).
- ped_req  in  1  pedestrian button (synchronous).
- m  out  1  advance to light FSM. Decoded from registers only; no input-to-output path.
- phase  out  3  mirrored light state.
- dwell_cnt  out  CNT_W  cycles spent in current phase.
- pend1  out  1  road-1 demand latched.
- pend2  out  1  road-2 demand latched.
- ped_walk  out  1  walk indication.

Behaviour:
- Phase encoding:
  - 0 = road2 green
  - 1 = road2 yellow
  - 2 = all-red, heading to road1
  - 3 = road1 green
  - 4 = road1 yellow
  - 5 = all-red, heading to road2
- Reset (async, rst_n=0): phase=0, dwell_cnt=0, pend1=pend2=0, ped_walk=0, so m=0.
- Mirror transitions, taken every clk edge:
  - 0: m ? 1 : 0
  - 1: m ? 3 : 2
  - 2: m ? 3 : 2
  - 3: m ? 4 : 3
  - 4: m ? 0 : 5
  - 5: m ? 0 : 5
  - Codes 6/7 are unreachable; if reached, return to 0 with m=0.
- dwell_cnt:
  - Cleared to 0 on any phase change.
  - Otherwise increments by 1 per cycle, saturating at 2^CNT_W-1 (no wrap).
- m decode, green phases 0/3 (the other road is road1 for phase 0, road2 for phase 3):
  - m=1 iff en AND ((dwell_cnt >= MIN_GREEN-1 AND other road's pend) OR dwell_cnt >= MAX_GREEN-1).
  - Green length: MIN_GREEN cycles with demand, MAX_GREEN cycles without.
- m decode, yellow phases 1/4: m=SKIP_ALLRED. Yellow always lasts exactly 1 cycle.
- m decode, all-red phases 2/5: m=1 iff en AND dwell_cnt >= ALLRED_T-1.
- en=0: m forced 0 in green and all-red phases; counters keep saturating. When en returns to 1, any elapsed thresholds take effect that same cycle.
- Demand latches:
  - pend1 set by car_req1=1; cleared on entry to phase 3.
  - pend2 set by car_req2=1; cleared on entry to phase 0.
  - If set and clear coincide, clear wins (that car is served by the green just starting).
- Reset mid-phase: all state returns to reset values immediately, with no partial-sequence recovery.

Optional Feature:
- Macro: TRAFFIC_SCHED_PED_EN.
- Defined:
  - ped_req latches a ped_pend flag.
  - On entry to phase 2 or 5 with ped_pend=1, the all-red threshold becomes ALLRED_T+PED_T.
  - ped_walk=1 while dwell_cnt >= ALLRED_T-1 within that extended window.
  - ped_pend clears on exit of that all-red phase; a new ped_req in the same cycle is retained (set wins over clear).
  - SKIP_ALLRED is ignored while ped_pend=1.
- Undefined: ped_req is ignored, ped_walk is tied 0, and ports remain for a stable interface.

Decomposition:
- Shared package traffic_pkg:
  - Phase localparams PH_G2, PH_Y2, PH_AR1, PH_G1, PH_Y1, PH_AR2 (3'b000..3'b101).
  - Helper functions is_green(phase) and is_allred(phase), also used by the light FSM and the bench.
- One sub-module, dwell_timer: CNT_W saturating counter with synchronous clear and async active-low reset.

Test Plan:
- Reset mid-sequence: hold in phase 3 with dwell_cnt=7, pulse rst_n low → phase=0, dwell_cnt=0, pend1/pend2=0, m=0 during reset and on release.
- No demand, en=1, defaults → phase 0 lasts 60 cycles, 1 cycle yellow, all-red 3 cycles, phase 3 lasts 60 cycles. Mirror matches light FSM state every cycle.
- car_req1 pulse at dwell_cnt=2 in phase 0 → pend1=1, m=1 at dwell_cnt=9, phase 1 next cycle, pend1 clears on entry to phase 3.
- car_req2 asserted in the same cycle phase 0 is entered → pend2 stays 0 (clear wins).
- en=0 from dwell_cnt=5 to 70 in phase 3 with pend2=1 → m=0 throughout. en=1 → m=1 that cycle.
- With TRAFFIC_SCHED_PED_EN: ped_req during phase 0 → phase 2 lasts 23 cycles, ped_walk high for cycles 3..23 (dwell_cnt 2..22), ped_pend clear after.
